// File: rtl/mux_buf.sv
// mux_buf: triple-buffered register bank.
// A writer fills the back bank and commits it with write_done; the reader
// adopts the newest committed frame at read_latch, so a frame is never torn.
// Optional feature macro: MUX_BUF_CLEAR_EN (zero-fill the bank recycled as
// back on every commit). The default build keeps stale data in that bank.
module mux_buf #(
  parameter int width   = 5,
  parameter int num_reg = 3,
  localparam int addr_width = (num_reg > 1) ? $clog2(num_reg) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] write_addr,
  input  logic [width-1:0]      write_data,
  input  logic                  write_enable,
  input  logic                  write_done,
  input  logic [addr_width-1:0] read_addr,
  input  logic                  read_latch,
  output logic [width-1:0]      read_data
);

  typedef logic [1:0] bank_idx_t;

  localparam logic [addr_width:0] NUM_REG_W = num_reg[addr_width:0];

  logic [width-1:0] bank [3][num_reg];

  bank_idx_t front, back, pending;
  bank_idx_t front_nxt, back_nxt, pending_nxt;
  logic      pend_valid, pend_valid_nxt;

  logic             wr_hit;
  logic             rd_ok;
  logic [width-1:0] rd_word;

  assign wr_hit = write_enable && ({1'b0, write_addr} < NUM_REG_W);
  assign rd_ok  = {1'b0, read_addr} < NUM_REG_W;

  // Role rotation: decide which bank is front/back/pending after this edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    front_nxt      = front;
    back_nxt       = back;
    pending_nxt    = pending;
    pend_valid_nxt = pend_valid;
    unique case ({write_done, read_latch})
      2'b10: begin
        // Commit: the filled back becomes pending; an older pending frame
        // is dropped by being recycled as the new back.
        back_nxt       = pending;
        pending_nxt    = back;
        pend_valid_nxt = 1'b1;
      end
      2'b01: begin
        if (pend_valid) begin
          front_nxt      = pending;
          pending_nxt    = front;
          pend_valid_nxt = 1'b0;
        end
      end
      2'b11: begin
        // Commit and latch together: the just-committed frame goes straight
        // to the reader, bypassing pending.
        front_nxt      = back;
        back_nxt       = front;
        pend_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Role registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      front      <= 2'd0;
      back       <= 2'd1;
      pending    <= 2'd2;
      pend_valid <= 1'b0;
    end else begin
      front      <= front_nxt;
      back       <= back_nxt;
      pending    <= pending_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  // Bank storage: writes always land in the current back bank, which is
  // the committed bank when write_done is asserted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the banks are reset explicitly because the reader must see an
    // all-zero frame after reset; this makes them flops, not RAM.
    if (!rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int r = 0; r < num_reg; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else begin
`ifdef MUX_BUF_CLEAR_EN
      // The recycled bank is never the one being written this edge.
      if (write_done) begin
        for (int r = 0; r < num_reg; r++) begin
          bank[back_nxt][r] <= '0;
        end
      end
`endif
      if (wr_hit) begin
        bank[back][write_addr] <= write_data;
      end
    end
  end

  // Read word from the post-edge front bank; a same-cycle write into that
  // bank (commit + latch) is forwarded so the new frame is seen at once.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = bank[front_nxt][read_addr];
      if (wr_hit && (back == front_nxt) && (write_addr == read_addr)) begin
        rd_word = write_data;
      end
    end
  end

  // Registered read output, one cycle of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else begin
      read_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_mux_buf.sv
// Testbench for mux_buf (width=5, num_reg=3). A frame-level reference model
// moves whole buffers between reader, pending and writer roles; expected
// read results are queued by the driver and checked by a separate monitor.
module tb_mux_buf;

  localparam int W = 5;
  localparam int N = 3;

  logic         clk;
  logic         rst;
  logic [1:0]   write_addr;
  logic [W-1:0] write_data;
  logic         write_enable;
  logic         write_done;
  logic [1:0]   read_addr;
  logic         read_latch;
  logic [W-1:0] read_data;

  mux_buf #(.width(W), .num_reg(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .write_done   (write_done),
    .read_addr    (read_addr),
    .read_latch   (read_latch),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q [$];

  // Reference model: the contents of each role's buffer.
  int  m_front [N];
  int  m_back  [N];
  int  m_pend  [N];
  bit  m_pv;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_front[i] = 0;
      m_back[i]  = 0;
      m_pend[i]  = 0;
    end
    m_pv = 1'b0;
  endtask

  // Applies one clock's worth of inputs to the model and returns the value
  // read_data must show after that edge.
  function automatic int model_step(bit we, int wa, int wd, bit wdn, int ra, bit rl);
    int tmp [N];
    if (we && wa < N) m_back[wa] = wd;
    if (wdn && !rl) begin
      tmp    = m_pend;
      m_pend = m_back;
`ifdef MUX_BUF_CLEAR_EN
      for (int i = 0; i < N; i++) m_back[i] = 0;
`else
      m_back = tmp;
`endif
      m_pv = 1'b1;
    end else if (rl && !wdn) begin
      if (m_pv) begin
        tmp     = m_front;
        m_front = m_pend;
        m_pend  = tmp;
        m_pv    = 1'b0;
      end
    end else if (rl && wdn) begin
      tmp     = m_front;
      m_front = m_back;
`ifdef MUX_BUF_CLEAR_EN
      for (int i = 0; i < N; i++) m_back[i] = 0;
`else
      m_back = tmp;
`endif
      m_pv = 1'b0;
    end
    return (ra < N) ? m_front[ra] : 0;
  endfunction

  // Driver: one call per clock cycle, inputs change on the falling edge.
  task automatic step(input bit we, input int wa, input int wd, input bit wdn,
                      input int ra, input bit rl);
    int exp;
    logic [31:0] wa_v, wd_v, ra_v;
    @(negedge clk);
    wa_v = wa; wd_v = wd; ra_v = ra;
    write_enable = we;
    write_addr   = wa_v[1:0];
    write_data   = wd_v[W-1:0];
    write_done   = wdn;
    read_addr    = ra_v[1:0];
    read_latch   = rl;
    exp = model_step(we, wa, wd, wdn, ra, rl);
    exp_q.push_back(exp[W-1:0]);
  endtask

  task automatic idle_read(input int ra);
    step(1'b0, 0, 0, 1'b0, ra, 1'b0);
  endtask

  task automatic write_frame(input int d0, input int d1, input int d2);
    step(1'b1, 0, d0, 1'b0, 0, 1'b0);
    step(1'b1, 1, d1, 1'b0, 1, 1'b0);
    step(1'b1, 2, d2, 1'b0, 2, 1'b0);
  endtask

  // Monitor: read_data is valid every cycle; compare after each rising edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      check("read_data", read_data, exp_q.pop_front());
    end
  end

  initial begin
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    write_done   = 1'b0;
    read_addr    = '0;
    read_latch   = 1'b0;
    rst          = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_read_data", read_data, 5'h00);
    @(negedge clk);
    rst = 1'b1;

    // Reset state: every address reads 0, a latch with no commit keeps 0.
    for (int a = 0; a < 4; a++) idle_read(a);
    step(1'b0, 0, 0, 1'b0, 1, 1'b1);

    // Basic frame.
    write_frame(5'h04, 5'h01, 5'h09);
    step(1'b0, 0, 0, 1'b1, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    idle_read(1);
    idle_read(2);

    // No tearing: write B while reading A, then commit and latch.
    write_frame(5'h11, 5'h12, 5'h13);
    for (int a = 0; a < 3; a++) idle_read(a);
    step(1'b0, 0, 0, 1'b1, 0, 1'b0);
    idle_read(1);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    idle_read(1);
    idle_read(2);

    // Overwrite pending: commit A, commit B, latch -> B; latch again -> B.
    write_frame(5'h0A, 5'h0B, 5'h0C);
    step(1'b0, 0, 0, 1'b1, 0, 1'b0);
    write_frame(5'h1A, 5'h1B, 5'h1C);
    step(1'b0, 0, 0, 1'b1, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    idle_read(1);
    step(1'b0, 0, 0, 1'b0, 2, 1'b1);

    // Simultaneous write + commit + latch.
    step(1'b1, 0, 5'h05, 1'b0, 0, 1'b0);
    step(1'b1, 1, 5'h06, 1'b0, 1, 1'b0);
    step(1'b1, 2, 5'h1F, 1'b1, 2, 1'b1);
    idle_read(0);
    idle_read(1);

    // Out of range write and read; recycled back bank is then read back.
    step(1'b1, 3, 5'h11, 1'b0, 3, 1'b0);
    for (int a = 0; a < 4; a++) idle_read(a);
    step(1'b0, 0, 0, 1'b1, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    idle_read(1);
    idle_read(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 60,
           $urandom_range(0, 3),
           $urandom_range(0, 31),
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 3),
           $urandom_range(0, 99) < 20);
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    write_enable = 1'b0;
    write_done   = 1'b0;
    read_latch   = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
